// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings and FSM state for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op >= OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic          w_ge;

  // Multiply keeps {hi,lo} as the partial product with the multiplier draining out of lo.
  assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
  // Divide keeps the partial remainder in hi and shifts quotient bits into lo.
  assign w_shift = {i_hi, i_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opnd});

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (i_is_div) begin
      o_hi = w_ge ? (w_shift[XLEN-1:0] - i_opnd) : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  op_e             r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_result;
  logic            r_neg;
  logic            r_neg_rem;
  logic            r_out_valid;

  op_e               w_op;
  logic              w_accept;
  logic              w_is_div;
  logic              w_r_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_div_zero;
  logic              w_overflow;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_special;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN-1:0]   w_fixed;
  logic [2*XLEN-1:0] w_prod;

  assign w_op       = op_e'(op);
  assign w_accept   = (r_state == S_IDLE) && in_valid && !flush;
  assign w_is_div   = op_is_div(w_op);
  assign w_r_is_div = op_is_div(r_op);
  assign w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg    = w_a_signed && a[XLEN-1];
  assign w_b_neg    = w_b_signed && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  assign w_div_zero = w_is_div && (b == '0);
  assign w_overflow = ((w_op == OP_DIV) || (w_op == OP_REM)) && (a == INT_MIN) && (b == ALL_ONES);

  // Signed overflow on REM falls through to the zero default.
  always_comb begin
    w_special = '0;
    if (w_div_zero)
      w_special = ((w_op == OP_DIV) || (w_op == OP_DIVU)) ? ALL_ONES : a;
    else if (w_op == OP_DIV)
      w_special = a;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (w_r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // Sign fix-up is applied to the final step output so DONE is entered on the last iteration edge.
  assign w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};

  always_comb begin
    w_fixed = '0;
    case (r_op)
      OP_MUL:                       w_fixed = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fixed = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fixed = r_neg ? -w_lo : w_lo;
      default:                      w_fixed = r_neg_rem ? -w_hi : w_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_result    <= '0;
      r_neg       <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= w_op;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_hi      <= '0;
            r_lo      <= w_is_div ? w_a_mag : w_b_mag;
            r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
            if (w_div_zero || w_overflow) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_special;
              r_cnt       <= '0;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= CW'(XLEN);
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_fixed;
            end
          end
        end
        S_DONE: begin
          if (flush || out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_result    <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_out_valid ? r_result : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at XLEN=32
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency counts the cycle that starts at the acceptance edge as cycle 1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] ia, input logic [31:0] ib,
                       output int lat, output logic [31:0] res);
    @(negedge clk);
    in_valid = 1'b1;
    op = f3;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] ia,
                     input logic [31:0] ib, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] res;
    issue(f3, ia, ib, lat, res);
    check_eq($sformatf("%s.res", tag), res, exp);
    check_eq($sformatf("%s.lat", tag), lat, exp_lat);
    @(posedge clk);
    #1;
    check_eq($sformatf("%s.idle", tag), in_ready, 1);
  endtask

  task automatic abort_calc(input bit use_rst);
    bit seen;
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'd5;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq(use_rst ? "rst.busy9" : "flush.busy9", busy, 1);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    check_eq(use_rst ? "rst.in_ready" : "flush.in_ready", in_ready, 1);
    check_eq(use_rst ? "rst.busy" : "flush.busy", busy, 0);
    rst = 1'b0;
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq(use_rst ? "rst.no_valid" : "flush.no_valid", seen, 0);
    run(use_rst ? "rst.divu9_3" : "flush.divu9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33);
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.in_ready", in_ready, 1);
    check_eq("reset.out_valid", out_valid, 0);
    check_eq("reset.busy", busy, 0);
    check_eq("reset.result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    run("mul_7_m3",   3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mul_big",    3'd0, 32'h12345678, 32'd9,        32'hA3D70A38, 33);
    run("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulhsu_ones",3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run("divu_100_7", 3'd5, 32'd100,      32'd7,        32'd14,       33);
    run("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        33);
    run("divu_5_0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run("remu_5_0",   3'd7, 32'd5,        32'd0,        32'd5,        1);
    run("div_m7_0",   3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    run("rem_m7_0",   3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    run("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Consumer stalls: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
    check_eq("hold.lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("hold%0d.valid", i), out_valid, 1);
      check_eq($sformatf("hold%0d.res", i), result, 32'hFFFFFFFE);
      check_eq($sformatf("hold%0d.in_ready", i), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release.in_ready", in_ready, 1);
    check_eq("release.out_valid", out_valid, 0);
    check_eq("release.result", result, 0);

    abort_calc(1'b0);
    abort_calc(1'b1);

    // Flush or reset in IDLE must block a presented request.
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    op = 3'd0;
    a = 32'd3;
    b = 32'd4;
    @(posedge clk);
    #1;
    check_eq("idle_flush.busy", busy, 0);
    flush = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_rst.busy", busy, 0);
    check_eq("idle_rst.in_ready", in_ready, 1);
    rst = 1'b0;
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  RISC-V M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port a  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-008 SHALL have port b  input  XLEN  rs2 operand (divisor / multiplier).
REQ-009 SHALL have port flush  input  1  abandon any operation in flight.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; a request is accepted on a clock edge where in_valid & in_ready & ~flush.
REQ-016 SHALL capture op, a, b at acceptance; later input changes have no effect.
REQ-017 SHALL, on acceptance of a normal operation, go IDLE -> CALC and iterate exactly XLEN cycles (radix-2 shift-add multiply / restoring shift-subtract divide), then go CALC -> DONE; out_valid rises XLEN+1 cycles after the acceptance edge.
REQ-018 SHALL compute signed ops on magnitudes and fix sign at the end: product sign = sign(a)^sign(b) (MULHSU: sign(a) only), quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-019 SHALL return low XLEN bits of the 2*XLEN product for MUL and high XLEN bits for MULH/MULHSU/MULHU.
REQ-020 SHALL, for divide by zero (b == 0), go IDLE -> DONE directly (out_valid one cycle after acceptance): DIV/DIVU result all ones, REM/REMU result = a.
REQ-021 SHALL, for signed overflow (DIV/REM, a = -2^(XLEN-1), b = -1), go IDLE -> DONE directly: DIV result = a, REM result = 0.
REQ-022 SHALL hold out_valid and result stable in DONE until out_valid & out_ready, then return to IDLE on that edge.
REQ-023 SHALL, when flush is high in CALC or DONE, return to IDLE on that edge without asserting out_valid afterwards; flush in IDLE blocks acceptance even if in_valid is high.
REQ-024 SHALL drive result = 0 whenever out_valid is low.
REQ-025 SHALL use an iteration counter of $clog2(XLEN)+1 bits, loaded at acceptance, with no wrap beyond XLEN iterations.

Reset
REQ-026 SHALL, when rst is high on a clock edge, enter IDLE regardless of state: in_ready = 1, out_valid = 0, busy = 0, result = 0, counter = 0.
REQ-027 SHALL give rst priority over flush and in_valid; a request presented with rst high is not accepted.

Structure
REQ-028 SHALL take op encodings (funct3 enum) and the FSM state typedef from shared package muldiv_pkg.
REQ-029 SHALL place the per-iteration add/subtract-shift step in one sub-module, muldiv_step, instantiated once; FSM, operand capture, sign fix-up and special cases stay in muldiv_unit.

Verification (XLEN = 32)
REQ-030 SHALL check MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance.
REQ-031 SHALL check a=b=0x80000000 MULH -> 0x40000000; a=b=0xFFFFFFFF MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF.
REQ-032 SHALL check a=0xFFFFFFF9 (-7), b=2: DIV -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 SHALL check a=5, b=0: DIVU -> 0xFFFFFFFF, REMU -> 5; a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0; each with out_valid one cycle after acceptance.
REQ-034 SHALL check out_ready low for 10 cycles in DONE -> result and out_valid stable, in_ready low; out_ready high -> IDLE next edge, in_ready = 1.
REQ-035 SHALL check flush (and separately rst) on the 10th CALC cycle -> IDLE next edge, out_valid never asserted, and a following DIVU 9/3 returns 3.
